// File: rtl/player_motion_controller_if.sv
// Key/frame inputs and sprite outputs of the player motion controller.
// master drives keys and frameTick; slave is the controller.
interface player_motion_controller_if;
    logic       frameTick;
    logic [3:0] keys;
    logic [7:0] xSprite;
    logic [8:0] ySprite;
    logic [3:0] ROMId;
    logic       airborne;
    logic       updateDone;

    modport master (
        output frameTick, keys,
        input  xSprite, ySprite, ROMId, airborne, updateDone
    );

    modport slave (
        input  frameTick, keys,
        output xSprite, ySprite, ROMId, airborne, updateDone
    );
endinterface

// File: rtl/player_motion_controller.sv
// Per-frame player sprite sequencer: STAND/RUN/JUMP/FALL with jump and gravity.
// All state advances on the clock edge following a frameTick pulse.
module player_motion_controller #(
    parameter logic [7:0] X_START    = 8'd40,
    parameter logic [7:0] X_MIN      = 8'd0,
    parameter logic [7:0] X_MAX      = 8'd208,
    parameter logic [7:0] X_STEP     = 8'd2,
    parameter logic [8:0] FLOOR_Y    = 9'd280,
    parameter logic [4:0] JUMP_VEL   = 5'd12,
    parameter logic [4:0] GRAVITY    = 5'd1,
    parameter logic [4:0] MAX_FALL   = 5'd12,
    parameter logic [2:0] RUN_FRAMES = 3'd4,
    parameter logic [3:0] ANIM_DIV   = 4'd4
) (
    input  logic                       clock,
    input  logic                       reset,
    player_motion_controller_if.slave  io
);
    typedef enum logic [1:0] {STAND, RUN, JUMP, FALL} state_t;

    state_t     state;
    logic [3:0] ks1, ks2;
    logic [7:0] xr;
    logic [8:0] yr;
    logic [4:0] vel;
    logic [3:0] rom;
    logic       air, done, jumpPrev;
    logic [2:0] animIdx;
    logic [3:0] animDiv;

    logic jp, lp, rp, dir, jumpEdge, unused_key;
    assign jp         = ~ks2[0];
    assign lp         = ~ks2[2];
    assign rp         = ~ks2[3];
    assign unused_key = ks2[1];
    assign dir        = lp | rp;
    assign jumpEdge   = jp & ~jumpPrev;

    // Horizontal step, widened to 9 bits so the clamp sees overflow.
    logic [8:0] xSum, xLow;
    logic [7:0] xNext;
    always_comb begin
        xSum  = {1'b0, xr} + {1'b0, X_STEP};
        xLow  = {1'b0, X_MIN} + {1'b0, X_STEP};
        xNext = xr;
        if (rp && !lp)
            xNext = (xSum > {1'b0, X_MAX}) ? X_MAX : xSum[7:0];
        else if (lp && !rp)
            xNext = ({1'b0, xr} < xLow) ? X_MIN : xr - X_STEP;
    end

    // Rising step; a launch applies the first step with JUMP_VEL immediately.
    logic [4:0] jv, jV;
    logic [8:0] jY;
    logic       jCeil, jToFall;
    always_comb begin
        jv      = (state == JUMP) ? vel : JUMP_VEL;
        jCeil   = yr < {4'd0, jv};
        jToFall = jCeil | (jv <= GRAVITY);
        jY      = jCeil ? 9'd0 : yr - {4'd0, jv};
        jV      = jToFall ? 5'd0 : jv - GRAVITY;
    end

    logic [5:0] fSum;
    logic [4:0] fV;
    logic [9:0] fY;
    logic       fLand;
    always_comb begin
        fSum  = {1'b0, vel} + {1'b0, GRAVITY};
        fV    = (fSum > {1'b0, MAX_FALL}) ? MAX_FALL : fSum[4:0];
        fY    = {1'b0, yr} + {5'd0, fV};
        fLand = fY >= {1'b0, FLOOR_Y};
    end

    // Animation counters as they will be if the next state is RUN.
    logic [2:0] aIdx;
    logic [3:0] aDiv;
    logic [3:0] runRom;
    always_comb begin
        aIdx = animIdx;
        aDiv = animDiv + 4'd1;
        if (state != RUN) begin
            aIdx = 3'd0;
            aDiv = 4'd0;
        end else if (animDiv == ANIM_DIV - 4'd1) begin
            aDiv = 4'd0;
            aIdx = (animIdx == RUN_FRAMES - 3'd1) ? 3'd0 : animIdx + 3'd1;
        end
        runRom = 4'd1 + {1'b0, aIdx};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= STAND;
            ks1      <= 4'b1111;
            ks2      <= 4'b1111;
            xr       <= X_START;
            yr       <= FLOOR_Y;
            vel      <= 5'd0;
            rom      <= 4'd0;
            air      <= 1'b0;
            done     <= 1'b0;
            jumpPrev <= 1'b0;
            animIdx  <= 3'd0;
            animDiv  <= 4'd0;
        end else begin
            ks1  <= io.keys;
            ks2  <= ks1;
            done <= io.frameTick;
            if (io.frameTick) begin
                xr       <= xNext;
                jumpPrev <= jp;
                if (state == JUMP || ((state == STAND || state == RUN) && jumpEdge)) begin
                    yr    <= jY;
                    vel   <= jV;
                    state <= jToFall ? FALL : JUMP;
                    rom   <= jToFall ? 4'd9 : 4'd8;
                    air   <= 1'b1;
                end else if (state == FALL) begin
                    if (fLand) begin
                        yr  <= FLOOR_Y;
                        vel <= 5'd0;
                        air <= 1'b0;
                        if (dir) begin
                            state   <= RUN;
                            animIdx <= aIdx;
                            animDiv <= aDiv;
                            rom     <= runRom;
                        end else begin
                            state <= STAND;
                            rom   <= 4'd0;
                        end
                    end else begin
                        yr  <= fY[8:0];
                        vel <= fV;
                        rom <= 4'd9;
                    end
                end else if (dir) begin
                    state   <= RUN;
                    animIdx <= aIdx;
                    animDiv <= aDiv;
                    rom     <= runRom;
                    air     <= 1'b0;
                end else begin
                    state <= STAND;
                    rom   <= 4'd0;
                    air   <= 1'b0;
                end
            end
        end
    end

    assign io.xSprite    = xr;
    assign io.ySprite    = yr;
    assign io.ROMId      = rom;
    assign io.airborne   = air;
    assign io.updateDone = done;
endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: directed scenarios plus random keys
// against a per-frame physics model.
module tb_player_motion_controller;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    player_motion_controller_if io();
    player_motion_controller_if io2();

    player_motion_controller dut (.clock(clock), .reset(reset), .io(io.slave));
    player_motion_controller #(.FLOOR_Y(9'd40), .JUMP_VEL(5'd31)) dut2 (
        .clock(clock), .reset(reset), .io(io2.slave));

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Model: positions as ints, upward speed while rising, downward speed while falling.
    int mx, my, mup, mfall, mrt;
    bit mair, mrise, mrun, mprev;
    logic [3:0] curk;

    task automatic mreset();
        mx = 40; my = 280; mup = 0; mfall = 0; mrt = 0;
        mair = 0; mrise = 0; mrun = 0; mprev = 0;
    endtask

    task automatic mrise_step();
        if (my < mup) begin
            my = 0; mup = 0; mrise = 0; mfall = 0;
        end else begin
            my = my - mup;
            mup = mup - 1;
            if (mup <= 0) begin mup = 0; mrise = 0; mfall = 0; end
        end
    endtask

    task automatic mfall_step(input bit d);
        mfall = (mfall + 1 > 12) ? 12 : mfall + 1;
        if (my + mfall >= 280) begin
            my = 280; mfall = 0; mair = 0; mrun = d; mrt = 0;
        end else my = my + mfall;
    endtask

    task automatic mstep(input logic [3:0] k);
        bit j, l, r, jed;
        j = !k[0]; l = !k[2]; r = !k[3];
        jed = j && !mprev;
        mprev = j;
        if (r && !l) mx = (mx + 2 > 208) ? 208 : mx + 2;
        else if (l && !r) mx = (mx < 2) ? 0 : mx - 2;
        if (!mair) begin
            if (jed) begin
                mair = 1; mrise = 1; mrun = 0; mup = 12;
                mrise_step();
            end else if (l || r) begin
                if (mrun) mrt++;
                else begin mrun = 1; mrt = 0; end
            end else mrun = 0;
        end else if (mrise) mrise_step();
        else mfall_step(l || r);
    endtask

    function automatic int mrom();
        if (mair) return mrise ? 8 : 9;
        if (mrun) return 1 + (mrt / 4) % 4;
        return 0;
    endfunction

    task automatic cmp(input string tag);
        chk({tag, ".x"}, io.xSprite, mx);
        chk({tag, ".y"}, io.ySprite, my);
        chk({tag, ".rom"}, io.ROMId, mrom());
        chk({tag, ".air"}, io.airborne, mair);
    endtask

    task automatic setk(input logic [3:0] k);
        @(negedge clock);
        io.keys = k;
        curk = k;
        repeat (2) @(negedge clock);
    endtask

    task automatic tick(input string tag);
        @(negedge clock);
        io.frameTick = 1'b1;
        @(negedge clock);
        io.frameTick = 1'b0;
        mstep(curk);
        chk({tag, ".done"}, io.updateDone, 1);
        cmp(tag);
        @(negedge clock);
        chk({tag, ".done_off"}, io.updateDone, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".x"}, io.xSprite, 40);
        chk({tag, ".y"}, io.ySprite, 280);
        chk({tag, ".rom"}, io.ROMId, 0);
        chk({tag, ".air"}, io.airborne, 0);
        chk({tag, ".done"}, io.updateDone, 0);
    endtask

    logic [3:0] romseq [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        romseq = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3};
        reset = 1'b1;
        io.keys = 4'hF; io.frameTick = 1'b0;
        io2.keys = 4'hF; io2.frameTick = 1'b0;
        curk = 4'hF;
        mreset();
        repeat (2) @(negedge clock);
        chk_reset("reset");
        reset = 1'b0;

        // Ceiling clamp on the short-floor instance.
        @(negedge clock) io2.keys = 4'b1110;
        repeat (2) @(negedge clock);
        io2.frameTick = 1'b1;
        @(negedge clock) io2.frameTick = 1'b0;
        chk("ceil1.y", io2.ySprite, 9);
        chk("ceil1.rom", io2.ROMId, 8);
        @(negedge clock) io2.frameTick = 1'b1;
        @(negedge clock) io2.frameTick = 1'b0;
        chk("ceil2.y", io2.ySprite, 0);
        chk("ceil2.rom", io2.ROMId, 9);
        chk("ceil2.air", io2.airborne, 1);

        setk(4'hF);
        repeat (5) tick("idle");
        chk("idle.x", io.xSprite, 40);
        chk("idle.rom", io.ROMId, 0);

        setk(4'b0111);
        for (int i = 0; i < 10; i++) begin
            tick("run");
            chk($sformatf("runseq%0d", i), io.ROMId, romseq[i]);
        end
        chk("run10.x", io.xSprite, 60);
        repeat (100) tick("runmax");
        chk("xmax", io.xSprite, 208);
        setk(4'b1011);
        repeat (104) tick("left");
        chk("xzero", io.xSprite, 0);
        repeat (2) tick("leftclamp");
        chk("xmin", io.xSprite, 0);

        setk(4'b1110);
        for (int i = 1; i <= 24; i++) begin
            tick("jump");
            if (i == 1) begin
                chk("jump1.y", io.ySprite, 268);
                chk("jump1.rom", io.ROMId, 8);
            end
            if (i == 12) begin
                chk("apex.y", io.ySprite, 202);
                chk("apex.rom", io.ROMId, 9);
            end
            if (i == 24) begin
                chk("land.y", io.ySprite, 280);
                chk("land.rom", io.ROMId, 0);
                chk("land.air", io.airborne, 0);
            end
        end
        repeat (3) tick("hold");
        chk("noretrig.y", io.ySprite, 280);
        setk(4'hF);
        tick("release");
        setk(4'b1110);
        tick("rejump");
        chk("rejump.y", io.ySprite, 268);
        repeat (23) tick("rejump_air");
        chk("rejump.land", io.airborne, 0);

        setk(4'hF);
        tick("pre_rj");
        setk(4'b0110);
        repeat (24) tick("runjump");
        chk("runjump.rom", io.ROMId, 1);
        chk("runjump.x", io.xSprite, 48);

        // Asynchronous reset in the middle of a jump.
        setk(4'hF);
        tick("pre_rst");
        setk(4'b1110);
        repeat (5) tick("rstjump");
        @(negedge clock) io.frameTick = 1'b1;
        #2 reset = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clock) io.frameTick = 1'b0;
        mreset();
        @(negedge clock) reset = 1'b0;
        setk(4'hF);
        tick("post_rst");

        // Key activity without frameTick must not move anything.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock) io.keys = 4'($urandom_range(0, 15));
            @(negedge clock);
            cmp("notick");
            chk("notick.done", io.updateDone, 0);
        end
        setk(4'hF);

        repeat (300) begin
            setk(4'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
